// File: rtl/axi2apb_arb_pkg.sv
// axi2apb_arb_pkg: shared types and helpers for the AXI-to-APB push-side arbiter.
package axi2apb_arb_pkg;

  typedef enum logic {IDLE, LOCKED} state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi2apb_fifo_arb_rr_pick.sv
// rr_pick: first valid index at or after i_ptr, wrapping at N-1 (rotate, priority-encode, unrotate).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);
  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) w_rot[k] = i_valid[(int'(i_ptr) + k) % N];
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = IW'(k);
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_any = |w_rot;
    o_idx = (int'(w_sum) >= N) ? IW'(int'(w_sum) - N) : w_sum[IW-1:0];
  end
endmodule

// File: rtl/axi2apb_fifo_arb.sv
// axi2apb_fifo_arb: round-robin arbiter sharing one command FIFO push port between NUM_REQ requesters,
// keeping multi-word transfers contiguous by locking the grant until the last word.
module axi2apb_fifo_arb
  import axi2apb_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  localparam int ID_BITS   = clog2_min1(NUM_REQ),
  localparam int OUT_WIDTH = ID_BITS + WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_push,
  output logic [OUT_WIDTH-1:0]     fifo_din,
  input  logic                     fifo_full,
  output logic [ID_BITS-1:0]       grant_id,
  output logic                     locked
);
  state_t             r_state, w_state_nxt;
  logic [ID_BITS-1:0] r_rr_ptr, r_lock_id, r_grant_id;
  logic [ID_BITS-1:0] w_rr_nxt, w_lock_nxt, w_gid_nxt, w_pick, w_g;
  logic               w_any, w_gnt, w_rdy;

  rr_pick #(.N(NUM_REQ), .IW(ID_BITS)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_idx   (w_pick)
  );

  // rstn gates ready so nothing is pushed while reset is held
  always_comb begin
    w_gnt       = (r_state == LOCKED) | w_any;
    w_g         = (r_state == LOCKED) ? r_lock_id : w_pick;
    w_rdy       = rstn & w_gnt & ~fifo_full;
    req_ready   = w_rdy ? (NUM_REQ'(1) << w_g) : '0;
    fifo_push   = w_rdy & req_valid[w_g];
    fifo_din    = {w_g, req_data[w_g*WIDTH +: WIDTH]};
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_id;
    w_gid_nxt   = r_grant_id;
    if (fifo_push) begin
      w_gid_nxt   = w_g;
      w_state_nxt = req_last[w_g] ? IDLE : LOCKED;
      w_rr_nxt    = req_last[w_g] ? ((w_g == ID_BITS'(NUM_REQ - 1)) ? '0 : w_g + 1'b1) : r_rr_ptr;
      w_lock_nxt  = req_last[w_g] ? r_lock_id : w_g;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_id  <= w_lock_nxt;
      r_grant_id <= w_gid_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign locked   = (r_state == LOCKED);
endmodule

// File: tb/tb_axi2apb_fifo_arb.sv
// tb_axi2apb_fifo_arb: directed bench with an expected-push scoreboard for the FIFO arbiter.
module tb_axi2apb_fifo_arb;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fifo_full = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_push;
  logic [9:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        locked;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_tot = 0;
  logic [9:0]  q[$];

  always #5 clk = ~clk;

  axi2apb_fifo_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  function automatic logic [9:0] w(input logic [1:0] id, input logic [7:0] d);
    return {id, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle: combinational outputs checked mid-cycle, registered outputs just after the edge
  task automatic tick(input logic [3:0] rdy, input logic [1:0] gid, input logic lk);
    logic [9:0] e;
    logic       ep;
    @(negedge clk);
    ep = (q.size() != 0);
    chk("ready", req_ready, rdy);
    chk("push", fifo_push, ep);
    if (ep) begin
      e = q.pop_front();
      if (fifo_push) chk("din", fifo_din, e);
    end
    @(posedge clk);
    #1;
    chk("grant_id", grant_id, gid);
    chk("locked", locked, lk);
  endtask

  initial begin
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_locked", locked, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) tick(4'b0000, 2'd0, 1'b0);
    req_valid = 4'hF;
    req_last = 4'hF;
    for (int c = 0; c < 8; c++) begin
      q.push_back(w(2'(c % 4), 8'(8'h10 + c % 4)));
      tick(4'b0001 << (c % 4), 2'(c % 4), 1'b0);
    end
    req_valid = 4'b0001;
    q.push_back(w(2'd0, 8'h10));
    tick(4'b0001, 2'd0, 1'b0);
    req_valid = 4'hF;
    req_last = 4'b1101;
    req_data[15:8] = 8'hA1;
    q.push_back(w(2'd1, 8'hA1));
    tick(4'b0010, 2'd1, 1'b1);
    req_data[15:8] = 8'hA2;
    q.push_back(w(2'd1, 8'hA2));
    tick(4'b0010, 2'd1, 1'b1);
    req_last = 4'hF;
    req_data[15:8] = 8'hA3;
    q.push_back(w(2'd1, 8'hA3));
    tick(4'b0010, 2'd1, 1'b0);
    req_data[15:8] = 8'h11;
    q.push_back(w(2'd2, 8'h12));
    tick(4'b0100, 2'd2, 1'b0);
    req_valid = 4'b0010;
    req_last = 4'b1101;
    req_data[15:8] = 8'hB1;
    q.push_back(w(2'd1, 8'hB1));
    tick(4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0001;
    tick(4'b0010, 2'd1, 1'b1);
    tick(4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0011;
    req_last = 4'hF;
    req_data[15:8] = 8'hB2;
    q.push_back(w(2'd1, 8'hB2));
    tick(4'b0010, 2'd1, 1'b0);
    req_valid = 4'hF;
    req_data[15:8] = 8'h11;
    q.push_back(w(2'd2, 8'h12));
    tick(4'b0100, 2'd2, 1'b0);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) tick(4'b0000, 2'd2, 1'b0);
    fifo_full = 1'b0;
    q.push_back(w(2'd3, 8'h13));
    tick(4'b1000, 2'd3, 1'b0);
    req_valid = 4'b0100;
    req_last = 4'b1011;
    req_data[23:16] = 8'hC1;
    q.push_back(w(2'd2, 8'hC1));
    tick(4'b0100, 2'd2, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_gid", grant_id, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_push", fifo_push, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req_valid = 4'b0101;
    req_last = 4'hF;
    req_data[23:16] = 8'h12;
    q.push_back(w(2'd0, 8'h10));
    tick(4'b0001, 2'd0, 1'b0);
    q.push_back(w(2'd2, 8'h12));
    tick(4'b0100, 2'd2, 1'b0);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/axi2apb_fifo_arb.md
Name: axi2apb_fifo_arb

Overview:
Round-robin push-side arbiter that shares one command FIFO between NUM_REQ requesters in the AXI-to-APB bridge.
Each requester offers words with valid/ready/last. The arbiter grants one requester and forwards its words, tagged with the requester ID, into the FIFO's push/din port while respecting the FIFO's full flag.
A multi-word transfer (last=0 … last=1) is kept contiguous in the FIFO by locking the grant until the last word has been pushed.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 8, payload bits per word
ID_BITS, derived = clog2(NUM_REQ) (minimum 1), width of the requester tag
OUT_WIDTH, derived = ID_BITS+WIDTH, width of the FIFO write word

Ports:
clk  in  1  clock
rstn  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  per-requester last word of transfer
req_data  in  NUM_REQ*WIDTH  packed payloads; requester i uses bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
fifo_push  out  1  FIFO push strobe
fifo_din  out  OUT_WIDTH  {grant_id, payload} written to the FIFO
fifo_full  in  1  FIFO full flag
grant_id  out  ID_BITS  currently granted requester
locked  out  1  high while a multi-word transfer is in progress

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- State registers: rr_ptr (ID_BITS, highest-priority index), lock_id (ID_BITS), state ∈ {IDLE, LOCKED}.
- Reset values: rr_ptr=0, lock_id=0, state=IDLE, locked=0, grant_id=0.
- While rstn is low, req_ready=0 and fifo_push=0.
- IDLE grant (combinational): the first requester with valid=1, scanning from rr_ptr upward with wrap at NUM_REQ-1→0. If no requester is valid: no grant and grant_id holds its last value.
- LOCKED grant: always lock_id, regardless of other valids.
- req_ready[g] = granted & !fifo_full. All other ready bits are 0.
- fifo_push = req_valid[g] & req_ready[g]. fifo_din = {g, req_data[g]}. This is zero-latency, a combinational path from valid to push.
- Push with last=1: state→IDLE; rr_ptr←g+1, wrapping to 0 after NUM_REQ-1.
- Push with last=0: state→LOCKED; lock_id←g; rr_ptr unchanged.
- LOCKED with the locked requester's valid=0: no push, grant held, no switching, waits indefinitely.
- fifo_full=1: no ready, no push, rr_ptr and state unchanged. The grant may change in IDLE because it is combinational.
- A single-word transfer is a push with last=1 from IDLE; the pointer advances the same cycle.
- Fairness: under continuous requests from all requesters, each requester receives at most one transfer before any other requester receives a second.
- Reset mid-burst: the lock is dropped immediately. Words already in the FIFO are not recalled.
- grant_id is registered: it updates on each push to g, resets to 0, and equals lock_id while locked.
- locked = (state==LOCKED).
- NUM_REQ that is not a power of 2: indices ≥ NUM_REQ are never granted, and the pointer wrap uses NUM_REQ-1.

Decomposition:
- Package axi2apb_arb_pkg holds:
  - the clog2 constant function;
  - the state enum {IDLE, LOCKED}.
- Sub-module rr_pick (combinational): inputs valid vector and rr_ptr; outputs any and idx. Implemented as a rotate, priority-encode and unrotate.
- The top level holds the state/pointer registers and the datapath mux.

Test Plan:
1. Reset, all valid=0 → req_ready=0, fifo_push=0, grant_id=0, locked=0; keep rstn high for 5 cycles with no push.
2. NUM_REQ=4, all valid, last=1, data=0x10+i, fifo_full=0 for 8 cycles → pushes fifo_din = {0,0x10}, {1,0x11}, {2,0x12}, {3,0x13}, then repeat from {0,0x10}. Exactly one ready per cycle.
3. Req1 sends 3 words (last=0,0,1: 0xA1, 0xA2, 0xA3) while req0, req2 and req3 are valid → three consecutive pushes tagged id 1, locked=1 across the first two. Next grant goes to req2 (rr_ptr=2).
4. Req1 locked, valid drops for 2 cycles while req0 is valid → no push and req0 not ready. Req1 resumes with last=1 → push, then req2 is scanned first.
5. fifo_full=1 for 3 cycles with req3 valid → fifo_push=0, req_ready=0, rr_ptr unchanged. fifo_full=0 → push {3,data} in the same cycle.
6. Assert rstn low mid-burst (locked=1, lock_id=2) → locked=0 and rr_ptr=0 immediately. After release with req0 and req2 valid → req0 is granted first.
